alu_req_arbiter: RTL

- Shares one ALU instance between two requesters.
- Accepts complete operations (OPA, OPB, CMD, MODE, CIN) over valid/ready, round-robin arbitrated.
- Sequences the ALU control inputs with command-dependent latency, captures result and flags, and returns them tagged with the requester ID.
- Sits between the requester ports and the ALU; the only block driving the ALU inputs.

---
 rtl/alu_req_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin front end sharing one ALU between two requesters.
// Define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority.
module alu_req_arbiter #(
  parameter int WIDTH   = 8,
  parameter int C_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [1:0]           REQ_VALID,
  output logic [1:0]           REQ_READY,
  input  logic [2*WIDTH-1:0]   REQ_OPA,
  input  logic [2*WIDTH-1:0]   REQ_OPB,
  input  logic [2*C_WIDTH-1:0] REQ_CMD,
  input  logic [1:0]           REQ_MODE,
  input  logic [1:0]           REQ_CIN,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic                 RSP_ID,
  output logic [WIDTH:0]       RSP_RES,
  output logic [5:0]           RSP_FLAGS,
  output logic                 ALU_CE,
  output logic                 ALU_MODE,
  output logic [C_WIDTH-1:0]   ALU_CMD,
  output logic [WIDTH-1:0]     ALU_OPA,
  output logic [WIDTH-1:0]     ALU_OPB,
  output logic                 ALU_CIN,
  output logic [1:0]           ALU_INP_VALID,
  input  logic [WIDTH:0]       ALU_RES,
  input  logic                 ALU_COUT,
  input  logic                 ALU_OFLOW,
  input  logic                 ALU_G,
  input  logic                 ALU_L,
  input  logic                 ALU_E,
  input  logic                 ALU_ERR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [1:0]         gnt;
  logic               gid;
  logic               accept;
  logic               exec_last;
  logic [WIDTH-1:0]   sel_opa;
  logic [WIDTH-1:0]   sel_opb;
  logic [C_WIDTH-1:0] sel_cmd;
  logic               sel_mode;
  logic               sel_cin;
  logic               sel_mul;

  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic [C_WIDTH-1:0] cmd_q;
  logic               mode_q;
  logic               cin_q;
  logic               id_q;
  logic [1:0]         cnt_q;
  logic [WIDTH:0]     res_q;
  logic [5:0]         flags_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = 2'b00;
    if (REQ_VALID[0])
      gnt = 2'b01;
    else if (REQ_VALID[1])
      gnt = 2'b10;
  end
`else
  logic last_q;

  always_comb begin
    gnt = REQ_VALID;
    if (&REQ_VALID)
      gnt = last_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      last_q <= 1'b1;
    else if (accept)
      last_q <= gid;
  end
`endif

  assign gid = gnt[1];

  assign sel_opa  = gid ? REQ_OPA[2*WIDTH-1:WIDTH]
                        : REQ_OPA[WIDTH-1:0];
  assign sel_opb  = gid ? REQ_OPB[2*WIDTH-1:WIDTH]
                        : REQ_OPB[WIDTH-1:0];
  assign sel_cmd  = gid ? REQ_CMD[2*C_WIDTH-1:C_WIDTH]
                        : REQ_CMD[C_WIDTH-1:0];
  assign sel_mode = REQ_MODE[gid];
  assign sel_cin  = REQ_CIN[gid];

  // multiply takes one extra ALU cycle
  assign sel_mul = sel_mode &
                   ((sel_cmd == C_WIDTH'(9)) |
                    (sel_cmd == C_WIDTH'(10)));

  assign accept    = (state_q == IDLE) & (|gnt);
  assign exec_last = (state_q == EXEC) & (cnt_q == 2'd0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (|gnt) state_d = EXEC;
      EXEC: if (cnt_q == 2'd0) state_d = RESP;
      RESP: if (RSP_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    REQ_READY     = 2'b00;
    ALU_CE        = 1'b0;
    ALU_INP_VALID = 2'b00;
    RSP_VALID     = 1'b0;
    unique case (state_q)
      IDLE: REQ_READY = RST_N ? gnt : 2'b00;
      EXEC: begin
        ALU_CE        = 1'b1;
        ALU_INP_VALID = 2'b11;
      end
      RESP: RSP_VALID = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      opa_q  <= '0;
      opb_q  <= '0;
      cmd_q  <= '0;
      mode_q <= 1'b0;
      cin_q  <= 1'b0;
      id_q   <= 1'b0;
      cnt_q  <= 2'd0;
    end else if (accept) begin
      opa_q  <= sel_opa;
      opb_q  <= sel_opb;
      cmd_q  <= sel_cmd;
      mode_q <= sel_mode;
      cin_q  <= sel_cin;
      id_q   <= gid;
      cnt_q  <= sel_mul ? 2'd2 : 2'd1;
    end else if ((state_q == EXEC) && (cnt_q != 2'd0)) begin
      cnt_q  <= cnt_q - 2'd1;
    end
  end

  // undriven or X flags from the ALU read back as 0
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      res_q   <= '0;
      flags_q <= '0;
    end else if (exec_last) begin
      res_q   <= ALU_RES;
      flags_q <= {ALU_COUT  === 1'b1,
                  ALU_OFLOW === 1'b1,
                  ALU_G     === 1'b1,
                  ALU_L     === 1'b1,
                  ALU_E     === 1'b1,
                  ALU_ERR   === 1'b1};
    end
  end

  assign ALU_MODE  = mode_q;
  assign ALU_CMD   = cmd_q;
  assign ALU_OPA   = opa_q;
  assign ALU_OPB   = opb_q;
  assign ALU_CIN   = cin_q;
  assign RSP_ID    = id_q;
  assign RSP_RES   = res_q;
  assign RSP_FLAGS = flags_q;

endmodule
